// File: rtl/cisr_pkg.sv
// Shared types for the SpMV result return path (accumulator -> host).
// Latency: n/a (types, constants and a pure byte-select helper).
// Backpressure: n/a.
package cisr_pkg;

  localparam int BYTES_PER_PAIR = 8;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_SEND  = 3'd2,
    TX_NEXT  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_e;

  // row_id occupies the low word so the flat 64-bit view is already in wire byte order.
  typedef struct packed {
    logic [31:0] value;
    logic [31:0] row_id;
  } pair_t;

  // Byte idx of a pair in transmit order: row_id LSB first, then value LSB first.
  function automatic logic [7:0] pair_byte(input pair_t p, input logic [2:0] idx);
    logic [63:0] flat;
    flat = p;
    return flat[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Single-clock FIFO of (row, value) result pairs with occupancy count.
// Latency: push visible in count/head the cycle after; pop frees the head next cycle.
// Backpressure: caller must not push when full nor pop when empty.
module result_fifo
  import cisr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push_i,
  input  pair_t                  push_dat_i,
  input  logic                   pop_i,
  output pair_t                  head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array: contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/result_transmitter.sv
// Buffers result pairs and ships them to the host as byte blocks over the block-transfer endpoint.
// Latency: trigger->start_transfer 1 cycle; >=2 cycles per byte; last ack->tx_done 2 cycles.
// Backpressure: res_ready drops when the FIFO holds NUM_ENTRIES pairs; bytes advance only on transfer_ready.
module result_transmitter
  import cisr_pkg::*;
#(
  parameter int NUM_ENTRIES   = 16,
  parameter int BURST_ENTRIES = 8
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         res_valid,
  input  logic [31:0]                  res_row_id,
  input  logic [31:0]                  res_value,
  output logic                         res_ready,
  input  logic                         flush,
  output logic                         start_transfer,
  output logic [7:0]                   uc_length,
  input  logic                         transfer_ready,
  input  logic                         transfer_busy,
  output logic [7:0]                   transfer_to_host,
  output logic                         tx_done,
  output logic [$clog2(NUM_ENTRIES):0] fifo_count
);

  localparam int             CW        = $clog2(NUM_ENTRIES) + 1;
  localparam logic [CW-1:0]  FULL_C    = CW'(NUM_ENTRIES);
  localparam logic [CW-1:0]  BURST_C   = CW'(BURST_ENTRIES);
  localparam logic [7:0]     BURST_LEN = 8'(BURST_ENTRIES * BYTES_PER_PAIR);

  tx_state_e     state_q, state_d;
  logic [7:0]    uc_length_q, uc_length_d;
  logic [7:0]    bytes_sent_q, bytes_sent_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic          flush_pending_q, flush_pending_d;
  logic          push, pop;
  pair_t         push_pair, head_pair;
  logic [CW-1:0] count;

  // Acceptance is based on the registered count only: a pop in the same cycle does not open a slot.
  assign res_ready = (count < FULL_C);
  assign push      = res_valid && res_ready;
  assign push_pair = '{value: res_value, row_id: res_row_id};

  result_fifo #(
    .DEPTH (NUM_ENTRIES)
  ) u_fifo (
    .clk        (clk),
    .rst_l      (rst_l),
    .push_i     (push),
    .push_dat_i (push_pair),
    .pop_i      (pop),
    .head_o     (head_pair),
    .count_o    (count)
  );

  // Block sequencing: snapshot length, request, walk bytes of head pairs, signal completion.
  always_comb begin
    state_d          = state_q;
    uc_length_d      = uc_length_q;
    bytes_sent_d     = bytes_sent_q;
    byte_idx_d       = byte_idx_q;
    flush_pending_d  = flush_pending_q | flush;
    pop              = 1'b0;
    start_transfer   = 1'b0;
    tx_done          = 1'b0;
    transfer_to_host = 8'h00;
    case (state_q)
      TX_IDLE: begin
        if (!transfer_busy &&
            ((count >= BURST_C) || (flush_pending_q && (count != '0)))) begin
          // Length is frozen here; pairs arriving later wait for the next block.
          uc_length_d = (count >= BURST_C) ? BURST_LEN : (8'(count) << 3);
          state_d     = TX_START;
        end else if (flush_pending_q && (count == '0) && !flush) begin
          flush_pending_d = 1'b0;
        end
      end
      TX_START: begin
        start_transfer = 1'b1;
        byte_idx_d     = 3'd0;
        bytes_sent_d   = 8'd0;
        state_d        = TX_SEND;
      end
      TX_SEND: begin
        transfer_to_host = pair_byte(head_pair, byte_idx_q);
        if (transfer_ready) state_d = TX_NEXT;
      end
      TX_NEXT: begin
        // Byte is held through this cycle; the new byte appears once back in SEND.
        transfer_to_host = pair_byte(head_pair, byte_idx_q);
        byte_idx_d       = byte_idx_q + 3'd1;
        bytes_sent_d     = bytes_sent_q + 8'd1;
        pop              = (byte_idx_q == 3'd7);
        state_d          = ((bytes_sent_q + 8'd1) == uc_length_q) ? TX_DONE : TX_SEND;
      end
      TX_DONE: begin
        tx_done = 1'b1;
        if ((count == '0) && !flush) flush_pending_d = 1'b0;
        state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // State and block bookkeeping registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q         <= TX_IDLE;
      uc_length_q     <= 8'd0;
      bytes_sent_q    <= 8'd0;
      byte_idx_q      <= 3'd0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      uc_length_q     <= uc_length_d;
      bytes_sent_q    <= bytes_sent_d;
      byte_idx_q      <= byte_idx_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign uc_length  = uc_length_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_result_transmitter.sv
// Self-checking bench for result_transmitter: table vectors, directed corner sequences,
// and randomized pair data checked against a queue-based model of the byte stream.
module tb_result_transmitter;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_row_id = '0;
  logic [31:0] res_value = '0;
  logic        flush = 1'b0;
  logic        transfer_ready = 1'b0;
  logic        transfer_busy = 1'b0;
  logic        res_ready;
  logic        start_transfer;
  logic [7:0]  uc_length;
  logic [7:0]  transfer_to_host;
  logic        tx_done;
  logic [4:0]  fifo_count;

  result_transmitter #(
    .NUM_ENTRIES   (16),
    .BURST_ENTRIES (8)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .res_valid        (res_valid),
    .res_row_id       (res_row_id),
    .res_value        (res_value),
    .res_ready        (res_ready),
    .flush            (flush),
    .start_transfer   (start_transfer),
    .uc_length        (uc_length),
    .transfer_ready   (transfer_ready),
    .transfer_busy    (transfer_busy),
    .transfer_to_host (transfer_to_host),
    .tx_done          (tx_done),
    .fifo_count       (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] row;
    logic [31:0] val;
  } mpair_t;

  typedef struct {
    logic [31:0] row;
    logic [31:0] val;
    logic [63:0] exp_bytes;  // first transmitted byte in [63:56]
  } vec_t;

  mpair_t     model_q[$];
  logic [7:0] got_q[$];
  vec_t       tbl[8];

  int n_vec = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  // Pulse counters, sampled before the edge updates state.
  always @(posedge clk) begin
    if (start_transfer) start_cnt++;
    if (tx_done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] row, input logic [31:0] val, output bit acc);
    mpair_t p;
    @(negedge clk);
    res_valid  = 1'b1;
    res_row_id = row;
    res_value  = val;
    acc        = res_ready;
    if (acc) begin
      p.row = row;
      p.val = val;
      model_q.push_back(p);
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic push_ok(input logic [31:0] row, input logic [31:0] val);
    bit acc;
    push(row, val, acc);
    check("push_accepted", 64'(acc), 64'd1);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (start_transfer) seen = 1'b1;
    end
    check("start_seen", 64'(seen), 64'd1);
  endtask

  // Endpoint model: waits a random gap per byte, captures it, acks for one cycle.
  task automatic recv_block(input int exp_len, input int max_gap, input int take);
    logic [7:0] v0;
    int         unstable;
    unstable = 0;
    got_q.delete();
    check("uc_length", 64'(uc_length), 64'(exp_len));
    for (int k = 0; k < take; k++) begin
      @(negedge clk);
      v0 = transfer_to_host;
      repeat ($urandom_range(max_gap, 0)) begin
        @(negedge clk);
        if (transfer_to_host !== v0) unstable++;
      end
      got_q.push_back(transfer_to_host);
      transfer_ready = 1'b1;
      @(negedge clk);
      transfer_ready = 1'b0;
    end
    check("byte_stable", 64'(unstable), 64'd0);
    if (take == exp_len) begin
      @(negedge clk);
      check("tx_done", 64'(tx_done), 64'd1);
    end
  endtask

  // Expected bytes come straight from the pair values: row LSB first, then value LSB first.
  task automatic check_model(input int n);
    mpair_t     p;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      if (model_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL model_underrun: got 0 pairs, expected %0d", n - i);
        return;
      end
      p = model_q.pop_front();
      for (int j = 0; j < 8; j++) begin
        e = (j < 4) ? 8'(p.row >> (8 * j)) : 8'(p.val >> (8 * (j - 4)));
        check("data_byte", 64'(got_q[8 * i + j]), 64'(e));
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_res_ready", 64'(res_ready), 64'd1);
    check("rst_start", 64'(start_transfer), 64'd0);
    check("rst_uc_length", 64'(uc_length), 64'd0);
    check("rst_tx_byte", 64'(transfer_to_host), 64'd0);
    check("rst_tx_done", 64'(tx_done), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
  endtask

  initial begin
    int s0;
    int d0;
    int k;
    bit acc;

    for (int i = 0; i < 8; i++) begin
      tbl[i].row       = 32'(i);
      tbl[i].val       = 32'h11223344 + 32'(i);
      tbl[i].exp_bytes = {8'(i), 24'h000000, 8'(8'h44 + i), 24'h332211};
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_l = 1'b1;
    @(negedge clk);

    // Full block of 8 table pairs, immediate acks
    s0 = start_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) push_ok(tbl[i].row, tbl[i].val);
    wait_start(10);
    recv_block(64, 0, 64);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        check("table_byte", 64'(got_q[8 * i + j]), 64'(tbl[i].exp_bytes[63 - 8 * j -: 8]));
      end
      void'(model_q.pop_front());
    end
    @(negedge clk);
    check("t1_starts", 64'(start_cnt - s0), 64'd1);
    check("t1_dones", 64'(done_cnt - d0), 64'd1);
    check("t1_fifo_count", 64'(fifo_count), 64'd0);

    // Partial block via flush; pending flag must clear afterwards
    for (int i = 0; i < 3; i++) push_ok($urandom, $urandom);
    flush_pulse();
    wait_start(10);
    recv_block(24, 1, 24);
    check_model(3);
    check("t2_fifo_count", 64'(fifo_count), 64'd0);
    push_ok($urandom, $urandom);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    check("t2_flush_cleared", 64'(start_cnt - s0), 64'd0);
    flush_pulse();
    wait_start(10);
    recv_block(8, 0, 8);
    check_model(1);

    // Endpoint busy holds off the block; stray acks outside SEND are ignored
    transfer_busy = 1'b1;
    for (int i = 0; i < 8; i++) push_ok($urandom, $urandom);
    s0 = start_cnt;
    transfer_ready = 1'b1;
    repeat (20) @(negedge clk);
    transfer_ready = 1'b0;
    check("t4_busy_no_start", 64'(start_cnt - s0), 64'd0);
    transfer_busy = 1'b0;
    @(negedge clk);
    check("t4_start_after_release", 64'(start_transfer), 64'd1);
    recv_block(64, 1, 64);
    check_model(8);

    // Pushes during a block with random ack gaps do not change the block
    for (int i = 0; i < 8; i++) push_ok($urandom, $urandom);
    wait_start(10);
    fork
      recv_block(64, 5, 64);
      begin
        repeat (6) @(negedge clk);
        push_ok($urandom, $urandom);
        push_ok($urandom, $urandom);
      end
    join
    check_model(8);
    check("t5_remaining", 64'(fifo_count), 64'd2);
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    check("t5_no_extra_start", 64'(start_cnt - s0), 64'd0);
    flush_pulse();
    wait_start(10);
    recv_block(16, 2, 16);
    check_model(2);

    // Fill to capacity with no acks; overflow refused; second block follows the first
    s0 = start_cnt;
    for (int i = 0; i < 16; i++) push_ok($urandom, $urandom);
    @(negedge clk);
    check("t3_full_count", 64'(fifo_count), 64'd16);
    check("t3_full_ready", 64'(res_ready), 64'd0);
    push($urandom, $urandom, acc);
    check("t3_overflow_refused", 64'(acc), 64'd0);
    check("t3_one_start", 64'(start_cnt - s0), 64'd1);
    recv_block(64, 0, 64);
    check("t3_after_first", 64'(fifo_count), 64'd8);
    check_model(8);
    wait_start(10);
    recv_block(64, 0, 64);
    check_model(8);
    check("t3_drained", 64'(fifo_count), 64'd0);

    // Randomized partial blocks
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(7, 1);
      for (int i = 0; i < k; i++) push_ok($urandom, $urandom);
      flush_pulse();
      wait_start(10);
      recv_block(8 * k, 3, 8 * k);
      check_model(k);
      check("rnd_drained", 64'(fifo_count), 64'd0);
    end

    // Reset in the middle of a block
    for (int i = 0; i < 8; i++) push_ok($urandom, $urandom);
    wait_start(10);
    recv_block(64, 2, 13);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    check_reset_outputs();
    model_q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    s0 = start_cnt;
    flush_pulse();
    repeat (20) @(negedge clk);
    check("t6_empty_flush_no_start", 64'(start_cnt - s0), 64'd0);
    check("t6_fifo_count", 64'(fifo_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/result_transmitter.md
# result_transmitter

Device-to-host return path of the SpMV engine: buffers (row index, value) result pairs produced after the multiply/accumulate stage and ships them to the host as byte blocks over the microcontroller block-transfer endpoint, the transmit counterpart of the row-length and value/index receivers. It sits between the accumulator output and the host-side port of the block-transfer core: it requests a transfer, supplies the length, and presents one byte per acknowledge.

## Interface
- NUM_ENTRIES, 16: FIFO depth in result pairs (power of two, ≥ BURST_ENTRIES).
- BURST_ENTRIES, 8: pairs per full block; BURST_ENTRIES*8 ≤ 255.
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- res_valid  in  1  result pair offered.
- res_row_id  in  32  row index of pair.
- res_value  in  32  accumulated value of pair.
- res_ready  out  1  FIFO can accept; push occurs on res_valid && res_ready.
- flush  in  1  one-cycle pulse: send partial block of all buffered pairs.
- start_transfer  out  1  one-cycle request to begin a host block.
- uc_length  out  8  block length in bytes, held for whole block.
- transfer_ready  in  1  one-cycle strobe: current byte consumed.
- transfer_busy  in  1  endpoint occupied; no new start while high.
- transfer_to_host  out  8  current byte, stable until consumed.
- tx_done  out  1  one-cycle pulse after last byte of a block consumed.
- fifo_count  out  $clog2(NUM_ENTRIES)+1  pairs buffered.

## Operation
- Byte order per pair: row_id[7:0], [15:8], [23:16], [31:24], then value[7:0] … value[31:24]; 8 bytes/pair.
- States: IDLE, START, SEND, NEXT, DONE.
- IDLE: trigger when transfer_busy==0 and (fifo_count ≥ BURST_ENTRIES, or flush_pending and fifo_count>0). Snapshot n = min(fifo_count, BURST_ENTRIES); uc_length <= n*8; -> START.
- START: start_transfer=1 for exactly this cycle; byte/pair counters cleared; -> SEND.
- SEND: transfer_to_host = byte (byte_idx) of FIFO head; on transfer_ready -> NEXT.
- NEXT: byte_idx++; if byte_idx was 7, pop head, pair_cnt++; if total bytes sent == uc_length -> DONE else -> SEND.
- DONE: tx_done=1 one cycle; flush_pending cleared if FIFO empty; -> IDLE.
- flush latched into flush_pending in any state; cleared only in DONE with empty FIFO or by reset. flush with empty FIFO: pending cleared next cycle, no transfer.
- res_ready = (fifo_count < NUM_ENTRIES). Push and pop in same cycle: count unchanged, both honoured; full FIFO with simultaneous pop still refuses the push (res_ready is registered-count based).
- Pairs pushed during a block are not included in that block (length fixed at snapshot).
- Counters/pointers wrap modulo NUM_ENTRIES.

## Timing
- Reset values: res_ready=1, start_transfer=0, uc_length=0, transfer_to_host=0, tx_done=0, fifo_count=0, state IDLE, FIFO empty, flush_pending=0.
- Reset mid-block: immediate return to IDLE, buffered pairs discarded.
- Push-to-visible: fifo_count updates the cycle after the push.
- Trigger to start_transfer: 1 cycle (IDLE->START).
- Per byte: minimum 2 cycles (SEND sees ready, NEXT advances); transfer_to_host changes only in the cycle after NEXT.
- transfer_ready outside SEND ignored.
- Last byte ack to tx_done: 2 cycles (NEXT, DONE).

## Structure
- Package cisr_pkg: tx state enum, BYTES_PER_PAIR=8 constant, pair struct {row_id, value}.
- Sub-module result_fifo: synchronous single-clock FIFO (push/pop/count/head, 64-bit entries), async active-low reset.
- Top FSM, byte mux, and length/byte counters in result_transmitter.

## Test plan
- Push 8 pairs (row 0..7, value 0x11223344+i), ack every byte immediately -> one start_transfer, uc_length=64, bytes 00 00 00 00 44 33 22 11 …, tx_done once, fifo_count=0.
- Push 3 pairs then flush -> uc_length=24, 24 bytes in order, tx_done, flush_pending cleared.
- Push 16 pairs with no acks -> res_ready=0 at count 16; 17th res_valid not accepted; after first block fifo_count=8, second block starts automatically.
- Hold transfer_busy=1 with 8 pairs buffered for 20 cycles -> no start_transfer; releases -> start 1 cycle later.
- Push 2 pairs during block of 8 with random ack gaps (0–5 cycles) -> block length stays 64, data stable between acks, 2 pairs remain.
- Assert rst_l=0 after byte 13 of a block -> all outputs at reset values, fifo_count=0; subsequent flush with empty FIFO produces no start.
